inst_dispatch: RTL and testbench
================================

INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 SHALL have parameter INST_LEN, default 220, instruction word width.
REQ-002 SHALL have parameter N_CH, default 4, transfer channels (1..12).
REQ-003 SHALL have parameter DEP_LEN, default 8, dependency mask width (>= N_CH+2).
REQ-004 SHALL have parameter CNT_W, default 16, counter width.
REQ-005 SHALL have parameter STALL_MAX, default 1024, stall-timeout threshold in cycles.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port instruct, input, INST_LEN, head word of the first-word-fall-through instruction FIFO.
REQ-009 SHALL have port inst_empty, input, 1, FIFO empty.
REQ-010 SHALL have port inst_req, output, 1, one-cycle FIFO pop.
REQ-011 SHALL have port comp_idle, input, 1, compute path idle.
REQ-012 SHALL have port ch_idle, input, N_CH, per-channel engine idle.
REQ-013 SHALL have port comp_conf, output, 1, one-cycle compute issue pulse.
REQ-014 SHALL have port ch_conf, output, N_CH, one-hot one-cycle channel issue pulse.
REQ-015 SHALL have port payload, output, INST_LEN-4-DEP_LEN, latched bits [INST_LEN-DEP_LEN-1:4] of the issued word.
REQ-016 SHALL have port err_illegal, output, 1, sticky illegal-type flag.
REQ-017 SHALL have port stall_to, output, 1, sticky stall-timeout flag.
REQ-018 SHALL have port stall_cnt, output, CNT_W, current stall length.
REQ-019 SHALL have port issue_cnt, output, CNT_W, issued-instruction count.

Function
REQ-020 SHALL decode type=instruct[3:0] and dep=instruct[INST_LEN-1 -: DEP_LEN].
- type 0 = compute; type k (1..N_CH) = channel k-1; type 15 = barrier; others = illegal.
REQ-021 SHALL compute eff_idle[j] = ch_idle[j] & ~pend[j].
- Head is ready when every set dep[j] (j<N_CH) has eff_idle[j]=1.
- dep[N_CH] set requires comp_idle=1.
- dep[DEP_LEN-1] set requires all eff_idle=1 and comp_idle=1.
- Type 1..N_CH additionally requires its own eff_idle=1.
- Barrier requires all eff_idle=1 and comp_idle=1.
REQ-022 SHALL run FSM IDLE/GAP.
- In IDLE with inst_empty=0 and head ready, next cycle is GAP with inst_req=1.
- On that same transition: matching conf=1, payload loaded, issue_cnt+1 (wraps).
- Barrier: inst_req only, no conf, no payload load.
REQ-023 SHALL pop an illegal-type word like a barrier but with no dependency wait, and set err_illegal.
REQ-024 SHALL hold GAP exactly one cycle with inst_req/conf at 0, then return to IDLE; peak rate is one issue per 2 cycles.
REQ-025 SHALL set pend[k] on a ch_conf[k] pulse.
- pend[k] clears on the first cycle ch_idle[k]=0, or 3 cycles after set, whichever is first.
- Same-cycle set and clear: set wins.
REQ-026 SHALL increment stall_cnt (saturating at all-ones) each cycle in IDLE with inst_empty=0 and head not ready; else load 0.
REQ-027 SHALL set stall_to when stall_cnt reaches STALL_MAX-1 while still stalled.
REQ-028 SHALL NOT issue or pop while inst_empty=1; stall_cnt = 0 in that case.
REQ-029 SHALL leave payload unchanged except on a compute/channel issue.

Reset
REQ-030 SHALL on rst=1 (any state, including GAP) go to IDLE with all of these zero on the next edge:
- inst_req, comp_conf, ch_conf, payload
- err_illegal, stall_to, stall_cnt, issue_cnt, pend
REQ-031 SHALL issue nothing during the reset cycle; a conf pending at reset is dropped.

Verification
REQ-032 Type 2, dep=0, ch_idle=all 1 -> one cycle later ch_conf=4'b0010 and inst_req=1 for exactly 1 cycle; issue_cnt=1.
REQ-033 Type 1 with dep[1]=1, ch_idle[1]=0 for 10 cycles -> stall_cnt reaches 10, no pop; 1 cycle after ch_idle[1]=1, ch_conf[0] pulses and stall_cnt=0.
REQ-034 Two back-to-back type-3 words, ch_idle[2] stuck 1 -> second issue occurs exactly 4 cycles after the first (pend timeout).
REQ-035 Type 9 with N_CH=4 -> inst_req pulses, no conf, err_illegal=1 until rst.
REQ-036 STALL_MAX=8, comp_idle=0 with barrier at head -> stall_to=1 on the 8th stall cycle; rst asserted during GAP -> all outputs 0 next cycle.

Source files
------------

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: pops a FWFT instruction FIFO and issues to compute
// or transfer channels once dependencies clear, one issue every two cycles.
module inst_dispatch #(
    parameter int INST_LEN  = 220,
    parameter int N_CH      = 4,
    parameter int DEP_LEN   = 8,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INST_LEN-1:0]          instruct,
    input  logic                         inst_empty,
    output logic                         inst_req,
    input  logic                         comp_idle,
    input  logic [N_CH-1:0]              ch_idle,
    output logic                         comp_conf,
    output logic [N_CH-1:0]              ch_conf,
    output logic [INST_LEN-DEP_LEN-5:0]  payload,
    output logic                         err_illegal,
    output logic                         stall_to,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             issue_cnt
);

    localparam int PW = INST_LEN - 4 - DEP_LEN;
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX - 1);

    typedef enum logic {S_IDLE, S_GAP} state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  comp_q, comp_d;
    logic [N_CH-1:0]       chc_q, chc_d;
    logic [PW-1:0]         pay_q, pay_d;
    logic                  ill_q, ill_d;
    logic                  to_q, to_d;
    logic [CNT_W-1:0]      stall_q, stall_d;
    logic [CNT_W-1:0]      issue_q, issue_d;
    logic [N_CH-1:0]       pend_q, pend_d;
    logic [1:0]            age_q [N_CH];
    logic [1:0]            age_d [N_CH];

    logic [3:0]            typ;
    logic [DEP_LEN-1:0]    dep;
    logic [N_CH-1:0]       eff_idle;
    logic [N_CH-1:0]       ch_sel;
    logic                  all_idle, dep_ok;
    logic                  is_comp, is_ch, is_bar, is_ill;
    logic                  ready, go, stall;
    logic                  unused_ok;

    assign typ       = instruct[3:0];
    assign dep       = instruct[INST_LEN-1 -: DEP_LEN];
    assign unused_ok = ^dep;
    assign eff_idle  = ch_idle & ~pend_q;
    assign all_idle  = (&eff_idle) & comp_idle;

    always_comb begin
        ch_sel = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (typ == 4'(j + 1)) ch_sel[j] = 1'b1;
        end
    end

    assign is_comp = (typ == 4'd0);
    assign is_ch   = |ch_sel;
    assign is_bar  = (typ == 4'd15);
    assign is_ill  = !(is_comp || is_ch || is_bar);

    assign dep_ok = (&(eff_idle | ~dep[N_CH-1:0]))
                  && (!dep[N_CH] || comp_idle)
                  && (!dep[DEP_LEN-1] || all_idle);

    // Illegal words are flushed without waiting on anything.
    assign ready = is_ill
                 || (dep_ok && (is_comp
                               || (is_ch && |(ch_sel & eff_idle))
                               || (is_bar && all_idle)));

    assign go    = (state_q == S_IDLE) && !inst_empty && ready;
    assign stall = (state_q == S_IDLE) && !inst_empty && !ready;

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        comp_d  = 1'b0;
        chc_d   = '0;
        pay_d   = pay_q;
        ill_d   = ill_q;
        to_d    = to_q;
        issue_d = issue_q;
        stall_d = '0;
        pend_d  = pend_q;
        age_d   = age_q;

        // Pending masks the gap before a started engine drops its idle.
        for (int j = 0; j < N_CH; j++) begin
            if (pend_q[j]) begin
                if (!ch_idle[j] || age_q[j] == 2'd2) pend_d[j] = 1'b0;
                else age_d[j] = age_q[j] + 2'd1;
            end
        end

        if (stall) begin
            stall_d = (&stall_q) ? stall_q : stall_q + 1'b1;
            if (stall_q >= STALL_LIM) to_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_GAP;
                    req_d   = 1'b1;
                    if (is_comp || is_ch) begin
                        comp_d  = is_comp;
                        chc_d   = ch_sel;
                        pay_d   = instruct[INST_LEN-DEP_LEN-1:4];
                        issue_d = issue_q + 1'b1;
                        for (int j = 0; j < N_CH; j++) begin
                            if (ch_sel[j]) begin
                                pend_d[j] = 1'b1;
                                age_d[j]  = 2'd0;
                            end
                        end
                    end
                    if (is_ill) ill_d = 1'b1;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            comp_q  <= 1'b0;
            chc_q   <= '0;
            pay_q   <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
            stall_q <= '0;
            issue_q <= '0;
            pend_q  <= '0;
            for (int j = 0; j < N_CH; j++) age_q[j] <= 2'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            comp_q  <= comp_d;
            chc_q   <= chc_d;
            pay_q   <= pay_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
            stall_q <= stall_d;
            issue_q <= issue_d;
            pend_q  <= pend_d;
            for (int j = 0; j < N_CH; j++) age_q[j] <= age_d[j];
        end
    end

    assign inst_req    = req_q;
    assign comp_conf   = comp_q;
    assign ch_conf     = chc_q;
    assign payload     = pay_q;
    assign err_illegal = ill_q;
    assign stall_to    = to_q;
    assign stall_cnt   = stall_q;
    assign issue_cnt   = issue_q;

endmodule

// File: tb/tb_inst_dispatch.sv
// Scoreboard bench for inst_dispatch: FIFO model feeds words, a monitor
// checks every pop against the queued expectation.
module tb_inst_dispatch;

    localparam int IL = 32;
    localparam int NC = 4;
    localparam int DL = 8;
    localparam int CW = 16;
    localparam int SM = 8;
    localparam int PW = IL - 4 - DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IL-1:0] instruct = '0;
    logic          inst_empty = 1'b1;
    logic          inst_req;
    logic          comp_idle = 1'b1;
    logic [NC-1:0] ch_idle = '1;
    logic          comp_conf;
    logic [NC-1:0] ch_conf;
    logic [PW-1:0] payload;
    logic          err_illegal;
    logic          stall_to;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] issue_cnt;

    inst_dispatch #(
        .INST_LEN(IL), .N_CH(NC), .DEP_LEN(DL), .CNT_W(CW), .STALL_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst), .instruct(instruct), .inst_empty(inst_empty),
        .inst_req(inst_req), .comp_idle(comp_idle), .ch_idle(ch_idle),
        .comp_conf(comp_conf), .ch_conf(ch_conf), .payload(payload),
        .err_illegal(err_illegal), .stall_to(stall_to),
        .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          comp;
        logic [NC-1:0] ch;
        logic [PW-1:0] pay;
        int            gap;
    } exp_t;

    exp_t          exp_q[$];
    logic [IL-1:0] fifo[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic void refresh();
        inst_empty = (fifo.size() == 0);
        instruct   = inst_empty ? '0 : fifo[0];
    endfunction

    function automatic logic [IL-1:0] mk(logic [DL-1:0] d, logic [PW-1:0] p,
                                         logic [3:0] t);
        return {d, p, t};
    endfunction

    task automatic push(logic [IL-1:0] w, logic c, logic [NC-1:0] ch,
                        logic [PW-1:0] p, int gap);
        fifo.push_back(w);
        exp_q.push_back('{c, ch, p, gap});
        refresh();
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // FIFO pop model
    always @(negedge clk) begin
        if (inst_req === 1'b1 && fifo.size() > 0) begin
            void'(fifo.pop_front());
            refresh();
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (inst_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pop want none");
            end else begin
                e = exp_q.pop_front();
                chk("comp_conf", 64'(comp_conf), 64'(e.comp));
                chk("ch_conf", 64'(ch_conf), 64'(e.ch));
                chk("payload", 64'(payload), 64'(e.pay));
                if (e.gap > 0) chk("issue_gap", 64'(cyc - last_cyc), 64'(e.gap));
            end
            last_cyc = cyc;
        end else if (!rst) begin
            chk("conf_without_req", 64'({comp_conf, ch_conf}), 64'(0));
        end
    end

    initial begin
        refresh();
        repeat (3) @(negedge clk);
        chk("rst_flags", 64'({inst_req, comp_conf, ch_conf, err_illegal, stall_to}), 0);
        chk("rst_payload", 64'(payload), 0);
        chk("rst_cnts", 64'({stall_cnt, issue_cnt}), 0);
        rst = 1'b0;

        push(mk(8'h00, 20'hABCDE, 4'd2), 1'b0, 4'b0010, 20'hABCDE, 0);
        drain();
        chk("issue_cnt_1", 64'(issue_cnt), 1);

        push(mk(8'h00, 20'h12345, 4'd0), 1'b1, 4'b0000, 20'h12345, 0);
        drain();
        chk("issue_cnt_2", 64'(issue_cnt), 2);

        ch_idle[1] = 1'b0;
        push(mk(8'h02, 20'h00001, 4'd1), 1'b0, 4'b0001, 20'h00001, 0);
        repeat (10) @(negedge clk);
        chk("stall_10", 64'(stall_cnt), 10);
        chk("no_pop_stalled", 64'(fifo.size()), 1);
        ch_idle[1] = 1'b1;
        @(negedge clk);
        chk("ch0_conf_after_idle", 64'(ch_conf), 64'(4'b0001));
        chk("stall_clr", 64'(stall_cnt), 0);
        drain();

        comp_idle = 1'b0;
        push(mk(8'h10, 20'h0BEEF, 4'd0), 1'b1, 4'b0000, 20'h0BEEF, 0);
        repeat (3) @(negedge clk);
        chk("stall_comp_dep", 64'(stall_cnt), 3);
        comp_idle = 1'b1;
        drain();

        ch_idle[3] = 1'b0;
        push(mk(8'h80, 20'h0CAFE, 4'd2), 1'b0, 4'b0010, 20'h0CAFE, 0);
        repeat (2) @(negedge clk);
        chk("stall_all_dep", 64'(stall_cnt), 2);
        ch_idle = '1;
        drain();
        chk("issue_cnt_5", 64'(issue_cnt), 5);

        push(mk(8'h00, 20'h33333, 4'd3), 1'b0, 4'b0100, 20'h33333, 0);
        push(mk(8'h00, 20'h44444, 4'd3), 1'b0, 4'b0100, 20'h44444, 4);
        drain();
        chk("issue_cnt_7", 64'(issue_cnt), 7);

        push(mk(8'h00, 20'h77777, 4'd15), 1'b0, 4'b0000, 20'h44444, 0);
        drain();
        chk("barrier_no_cnt", 64'(issue_cnt), 7);

        comp_idle = 1'b0;
        push(mk(8'hFF, 20'h99999, 4'd9), 1'b0, 4'b0000, 20'h44444, 0);
        drain();
        chk("err_illegal_set", 64'(err_illegal), 1);
        chk("empty_stall_zero", 64'(stall_cnt), 0);
        repeat (5) @(negedge clk);
        chk("err_illegal_sticky", 64'(err_illegal), 1);
        chk("payload_hold", 64'(payload), 64'(20'h44444));
        comp_idle = 1'b1;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_flags", 64'({err_illegal, stall_to}), 0);
        chk("rst2_issue", 64'(issue_cnt), 0);

        push(mk(8'h00, 20'h5A5A5, 4'd0), 1'b1, 4'b0000, 20'h5A5A5, 0);
        drain();
        comp_idle = 1'b0;
        push(mk(8'h00, 20'h00000, 4'd15), 1'b0, 4'b0000, 20'h5A5A5, 0);
        repeat (7) @(negedge clk);
        chk("stall_7", 64'(stall_cnt), 7);
        chk("stall_to_early", 64'(stall_to), 0);
        @(negedge clk);
        chk("stall_8", 64'(stall_cnt), 8);
        chk("stall_to_set", 64'(stall_to), 1);
        comp_idle = 1'b1;
        @(negedge clk);
        chk("barrier_pop_gap", 64'(inst_req), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_gap_flags", 64'({inst_req, comp_conf, ch_conf, err_illegal, stall_to}), 0);
        chk("rst_gap_payload", 64'(payload), 0);
        chk("rst_gap_cnts", 64'({stall_cnt, issue_cnt}), 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size() + fifo.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
